// File: rtl/timer_ctrl_pkg.sv
// Shared types and constants for the interval-timer sequencing controller.
// SNAP_* states exist only when TIMER_CTRL_SNAPSHOT_EN is defined.
package timer_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_LOAD_START = 2'd0,
        OP_STOP       = 2'd1,
        OP_SNAPSHOT   = 2'd2,
        OP_RSVD       = 2'd3
    } op_e;

    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
    localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
    localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
    localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

    localparam int unsigned CTRL_ITO   = 0;
    localparam int unsigned CTRL_CONT  = 1;
    localparam int unsigned CTRL_START = 2;
    localparam int unsigned CTRL_STOP  = 3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_PL,
        ST_WR_PH,
        ST_WR_CTRL,
        ST_WR_STOP,
        ST_CLR_STAT
`ifdef TIMER_CTRL_SNAPSHOT_EN
        ,
        ST_SNAP_WR,
        ST_SNAP_RL,
        ST_SNAP_RH,
        ST_SNAP_CAP
`endif
    } state_e;

    function automatic logic [15:0] ctrl_word(input logic stop, input logic start,
                                              input logic cont, input logic ito);
        logic [15:0] w;
        w             = '0;
        w[CTRL_STOP]  = stop;
        w[CTRL_START] = start;
        w[CTRL_CONT]  = cont;
        w[CTRL_ITO]   = ito;
        return w;
    endfunction

endpackage

// File: rtl/intro_qsys_timer_ctrl.sv
// Turns single requester commands into Avalon-MM write/read sequences for the
// interval timer and services its irq. Snapshot support: TIMER_CTRL_SNAPSHOT_EN.
module intro_qsys_timer_ctrl
    import timer_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_period,
    input  logic        cmd_continuous,
    output logic [2:0]  tmr_address,
    output logic        tmr_chipselect,
    output logic        tmr_write_n,
    output logic [15:0] tmr_writedata,
    input  logic [15:0] tmr_readdata,
    input  logic        tmr_irq,
    output logic        tick,
    output logic [15:0] tick_count,
    output logic        snap_valid,
    output logic [31:0] snap_value,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [31:0] period_q, period_d;
    logic        cont_q, cont_d;
    logic [15:0] tick_count_q, tick_count_d;
`ifdef TIMER_CTRL_SNAPSHOT_EN
    logic [31:0] snap_value_q, snap_value_d;
    logic        snap_valid_q, snap_valid_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            period_q     <= '0;
            cont_q       <= 1'b0;
            tick_count_q <= '0;
`ifdef TIMER_CTRL_SNAPSHOT_EN
            snap_value_q <= '0;
            snap_valid_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            cont_q       <= cont_d;
            tick_count_q <= tick_count_d;
`ifdef TIMER_CTRL_SNAPSHOT_EN
            snap_value_q <= snap_value_d;
            snap_valid_q <= snap_valid_d;
`endif
        end
    end

    // Next-state logic; irq in IDLE pre-empts any pending command.
    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        cont_d       = cont_q;
        tick_count_d = tick_count_q;
`ifdef TIMER_CTRL_SNAPSHOT_EN
        snap_value_d = snap_value_q;
        snap_valid_d = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (tmr_irq) begin
                    state_d = ST_CLR_STAT;
                end else if (cmd_valid) begin
                    period_d = cmd_period;
                    cont_d   = cmd_continuous;
                    case (op_e'(cmd_op))
                        OP_LOAD_START: state_d = ST_WR_PL;
                        OP_STOP:       state_d = ST_WR_STOP;
`ifdef TIMER_CTRL_SNAPSHOT_EN
                        OP_SNAPSHOT:   state_d = ST_SNAP_WR;
`endif
                        default:       state_d = ST_IDLE;
                    endcase
                end
            end
            ST_WR_PL:    state_d = ST_WR_PH;
            ST_WR_PH:    state_d = ST_WR_CTRL;
            ST_WR_CTRL:  state_d = ST_IDLE;
            ST_WR_STOP:  state_d = ST_IDLE;
            ST_CLR_STAT: begin
                tick_count_d = tick_count_q + 16'd1;
                state_d      = ST_IDLE;
            end
`ifdef TIMER_CTRL_SNAPSHOT_EN
            ST_SNAP_WR:  state_d = ST_SNAP_RL;
            ST_SNAP_RL:  state_d = ST_SNAP_RH;
            // readdata lags the address by one cycle, so each half lands a state later
            ST_SNAP_RH: begin
                snap_value_d[15:0] = tmr_readdata;
                state_d            = ST_SNAP_CAP;
            end
            ST_SNAP_CAP: begin
                snap_value_d[31:16] = tmr_readdata;
                snap_valid_d        = 1'b1;
                state_d             = ST_IDLE;
            end
`endif
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_address    = '0;
        tmr_writedata  = '0;
        unique case (state_q)
            ST_WR_PL: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = ADDR_PERIOD_L;
                tmr_writedata  = period_q[15:0];
            end
            ST_WR_PH: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = ADDR_PERIOD_H;
                tmr_writedata  = period_q[31:16];
            end
            ST_WR_CTRL: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = ADDR_CONTROL;
                tmr_writedata  = ctrl_word(1'b0, 1'b1, cont_q, 1'b1);
            end
            ST_WR_STOP: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = ADDR_CONTROL;
                tmr_writedata  = ctrl_word(1'b1, 1'b0, 1'b0, 1'b0);
            end
            ST_CLR_STAT: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = ADDR_STATUS;
            end
`ifdef TIMER_CTRL_SNAPSHOT_EN
            ST_SNAP_WR: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = ADDR_SNAP_L;
            end
            ST_SNAP_RL: begin
                tmr_chipselect = 1'b1;
                tmr_address    = ADDR_SNAP_L;
            end
            ST_SNAP_RH: begin
                tmr_chipselect = 1'b1;
                tmr_address    = ADDR_SNAP_H;
            end
`endif
            default: ;
        endcase
    end

    assign cmd_ready  = (state_q == ST_IDLE) && !tmr_irq;
    assign busy       = (state_q != ST_IDLE);
    assign tick       = (state_q == ST_CLR_STAT);
    assign tick_count = tick_count_q;

`ifdef TIMER_CTRL_SNAPSHOT_EN
    assign snap_valid = snap_valid_q;
    assign snap_value = snap_value_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^tmr_readdata;
    assign snap_valid   = 1'b0;
    assign snap_value   = '0;
`endif

endmodule

// File: doc/intro_qsys_timer_ctrl.md
# intro_qsys_timer_ctrl

Sequencing controller for the Avalon-MM interval timer slave (16-bit data, 3-bit word address, registered readdata, level irq). It turns single commands from a requester into the exact register write/read sequences the timer needs: load period and start, stop, and atomic snapshot. It also services the timer interrupt by clearing status and emitting a tick. It sits between a control client (e.g. a Nios-side bridge or a hardware scheduler) and the timer's s1 port.

## Interface
- No parameters. Widths are fixed by the timer register map.
- `clk` in 1: single clock, shared with the timer.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_op` in 2: 0 LOAD_START, 1 STOP, 2 SNAPSHOT, 3 reserved.
- `cmd_period` in 32: period for LOAD_START.
- `cmd_continuous` in 1: continuous-mode bit for LOAD_START.
- `tmr_address` out 3, `tmr_chipselect` out 1, `tmr_write_n` out 1, `tmr_writedata` out 16: timer slave port.
- `tmr_readdata` in 16: timer read data, valid one cycle after the address.
- `tmr_irq` in 1: timer interrupt, level.
- `tick` out 1: one-cycle pulse per serviced timeout.
- `tick_count` out 16: serviced-timeout counter.
- `snap_valid` out 1: one-cycle pulse, `snap_value` valid.
- `snap_value` out 32: last snapshot.
- `busy` out 1: the FSM is not in IDLE.

## Operation
- Timer word map: 0 status (write clears TO), 1 control {stop, start, cont, ito}, 2 period_l, 3 period_h, 4 snap_l, 5 snap_h.
- Command fields are latched on accept. Bus outputs are decoded only from the state register and latched fields.
- Idle bus state: chipselect 0, write_n 1, address 0, writedata 0.
- FSM states: IDLE, WR_PL, WR_PH, WR_CTRL, WR_STOP, CLR_STAT, SNAP_WR, SNAP_RL, SNAP_RH, SNAP_CAP.
- IDLE transitions:
  - `tmr_irq`=1 → CLR_STAT. The irq has priority over commands.
  - Else accept op 0 → WR_PL, op 1 → WR_STOP, op 2 → SNAP_WR, op 3 → IDLE (dropped, no bus activity).
- `cmd_ready` = IDLE && !`tmr_irq`.
- LOAD_START sequence:
  - WR_PL writes addr 2 = period[15:0].
  - WR_PH writes addr 3 = period[31:16].
  - WR_CTRL writes addr 1 = 0x5 | cont<<1, then IDLE.
  - The start write lands on the timer's force-reload cycle; start wins inside the timer.
- WR_STOP writes addr 1 = 0x8 (stop, irq disabled), then IDLE.
- CLR_STAT writes addr 0 = 0, pulses `tick`, increments `tick_count` (wraps 0xFFFF→0), then IDLE.
- SNAPSHOT sequence:
  - SNAP_WR writes addr 4.
  - SNAP_RL reads addr 4 (cs 1, write_n 1).
  - SNAP_RH reads addr 5 and captures readdata into `snap_value[15:0]`.
  - SNAP_CAP drives the idle bus, captures `snap_value[31:16]`, pulses `snap_valid` on exit, then IDLE.
- A timeout during any sequence keeps irq high; it is serviced on the first IDLE cycle after the sequence.
- Reset values: state IDLE, bus idle, `cmd_ready` 1 (unless irq), tick 0, tick_count 0, snap_valid 0, snap_value 0, busy 0.
- Async reset mid-sequence aborts immediately to the reset values. There is no partial-sequence recovery.

## Timing
- Accept at cycle 0 for every latency below.
- LOAD_START: bus writes in cycles 1, 2, 3; `cmd_ready` high again in cycle 4.
- STOP: write in cycle 1; ready in cycle 2.
- SNAPSHOT: write in cycle 1; reads in cycles 2 and 3; `snap_valid`=1 in cycle 5 with `cmd_ready` high.
- irq service: IDLE samples irq=1 in cycle n; CLR_STAT and `tick` in cycle n+1; the timer drops irq in n+2; IDLE in n+2.
- Back-to-back irq (continuous timer, period ≥ 3): one tick per timeout, none lost.
- The block adds no waitrequest handling. The timer is zero-wait.

## Configuration
- `TIMER_CTRL_SNAPSHOT_EN` defined: SNAPSHOT is implemented as described.
- `TIMER_CTRL_SNAPSHOT_EN` undefined:
  - The SNAP_* states are removed.
  - op 2 is treated like op 3: accepted, dropped, no bus activity.
  - `snap_valid` is tied 0 and `snap_value` is tied 0.

## Structure
- Shared package `timer_ctrl_pkg` holds:
  - the op enum,
  - the timer word-address constants (0–5),
  - the control bit positions (ITO 0, CONT 1, START 2, STOP 3),
  - the FSM state enum.
- The block is one flat module with no sub-module. The FSM and bus decode are small and tightly coupled.

## Test plan
- LOAD_START with period 0x0000_0010, cont=1 → writes (2,0x0010), (3,0x0000), (1,0x0007) in consecutive cycles; the timer then irqs every 17 clocks; `tick_count` reaches 3 after 3 timeouts.
- irq asserted while `cmd_valid`=1 in IDLE → CLR_STAT runs first, `cmd_ready`=0 in that cycle, and the command is accepted the following cycle.
- SNAPSHOT while the timer runs a period of 0x0001_0000 → `snap_value` equals the timer's internal counter at the SNAP_WR edge; the upper half is 0x0000 or 0x0001 consistent with the low half.
- STOP after LOAD_START cont=1 → write (1,0x0008); no further `tick`; the status running bit reads 0.
- op 3 and, with the macro undefined, op 2 → accepted in one cycle, chipselect never asserted, `snap_valid` stays 0.
- `reset_n` pulsed during WR_PH → outputs return to reset values asynchronously; the next LOAD_START completes normally.
